dec_final_adder_seq: RTL and testbench



---
 rtl/dec_mult_pkg.sv | 25 ++
 rtl/dec_digit_add.sv | 21 ++
 rtl/dec_final_adder_seq.sv | 110 +++++++++++
 tb/tb_dec_final_adder_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_mult_pkg.sv
// Shared types and digit helpers for the decimal multiplier datapath.
package dec_mult_pkg;

    localparam int DIG_W = 4;

    typedef logic [DIG_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // (4221) weighted code to its value; every code is legal and maps to 0..9.
    function automatic logic [3:0] d4221_value(input digit_t code);
        return {1'b0, code[3], 2'b00} + {2'b00, code[2], 1'b0}
             + {2'b00, code[1], 1'b0} + {3'b000, code[0]};
    endfunction

    // A value 0..9 in binary is already its BCD digit.
    function automatic digit_t to_bcd(input logic [3:0] v);
        return digit_t'(v);
    endfunction

endpackage

// File: rtl/dec_digit_add.sv
// One decimal digit position: recode two (4221) digits, add with carry, emit BCD.
module dec_digit_add
    import dec_mult_pkg::*;
(
    input  digit_t i_s,
    input  digit_t i_h,
    input  logic   i_c,
    output digit_t o_d,
    output logic   o_c
);

    logic [4:0] w_sum;

    // Binary sum is 0..19; above 9 wrap by ten and carry into the next digit.
    always_comb begin
        w_sum = {1'b0, d4221_value(i_s)} + {1'b0, d4221_value(i_h)} + {4'b0000, i_c};
        o_c   = (w_sum > 5'd9);
        o_d   = o_c ? to_bcd(4'(w_sum - 5'd10)) : to_bcd(w_sum[3:0]);
    end

endmodule

// File: rtl/dec_final_adder_seq.sv
// Chunk-serial final adder: redundant (4221) S + H + cin -> BCD product and decimal carry.
module dec_final_adder_seq
    import dec_mult_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIG_W*NDIG-1:0] s_4221,
    input  logic [DIG_W*NDIG-1:0] h_4221,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIG_W*NDIG-1:0] p_bcd,
    output logic                  cout
);

    localparam int NCH = NDIG / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = DIG_W * CHUNK;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIG_W*NDIG-1:0]   r_s;
    logic [DIG_W*NDIG-1:0]   r_h;
    logic [DIG_W*NDIG-1:0]   r_p;
    logic                    r_c;
    logic                    r_cout;
    logic [KW-1:0]           r_k;
    logic                    w_accept;
    logic                    w_last;
    logic [CW-1:0]           w_s_chunk;
    logic [CW-1:0]           w_h_chunk;
    logic [CW-1:0]           w_sum_chunk;
    logic [CHUNK:0]          w_c;

    assign w_s_chunk = r_s[int'(r_k)*CW +: CW];
    assign w_h_chunk = r_h[int'(r_k)*CW +: CW];
    assign w_c[0]    = r_c;
    assign w_last    = (r_k == K_LAST);
    assign w_accept  = in_valid & in_ready;
    assign p_bcd     = r_p;
    assign cout      = r_cout;

    // Carry ripples through the CHUNK digit adders within one clock.
    for (genvar i = 0; i < CHUNK; i++) begin : g_dig
        dec_digit_add u_add (
            .i_s (w_s_chunk[i*DIG_W +: DIG_W]),
            .i_h (w_h_chunk[i*DIG_W +: DIG_W]),
            .i_c (w_c[i]),
            .o_d (w_sum_chunk[i*DIG_W +: DIG_W]),
            .o_c (w_c[i+1])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; DONE passes out_ready through so a new pair can enter as the result leaves.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_nxt = in_valid ? ST_BUSY : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one chunk of digits per BUSY cycle; result holds untouched in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_h    <= '0;
            r_p    <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_s <= s_4221;
            r_h <= h_4221;
            r_c <= cin;
            r_k <= '0;
        end else if (r_state == ST_BUSY) begin
            r_p[int'(r_k)*CW +: CW] <= w_sum_chunk;
            r_c <= w_c[CHUNK];
            r_k <= w_last ? '0 : r_k + 1'b1;
            if (w_last) r_cout <= w_c[CHUNK];
        end
    end

endmodule

// File: tb/tb_dec_final_adder_seq.sv
// Bench: directed cases on a CHUNK=2 instance, random sweep on CHUNK=1,2,4,8 against a decimal model.
module tb_dec_final_adder_seq;

    localparam int NDIG = 8;
    localparam int W    = 4 * NDIG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] p;
        logic         co;
        int           cyc;
    } exp_t;

    // Integer value of an 8-digit (4221) word.
    function automatic int unsigned dval(input logic [W-1:0] w);
        int unsigned v;
        int unsigned scale;
        v = 0;
        scale = 1;
        for (int i = 0; i < NDIG; i++) begin
            v += (4 * int'(w[4*i+3]) + 2 * int'(w[4*i+2]) + 2 * int'(w[4*i+1]) + int'(w[4*i])) * scale;
            scale *= 10;
        end
        return v;
    endfunction

    // Reference: {cout, p_bcd} from plain decimal arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] h, input logic c);
        int unsigned t;
        logic co;
        logic [W-1:0] p;
        t = dval(s) + dval(h) + int'(c);
        co = (t >= 100000000);
        if (co) t -= 100000000;
        p = '0;
        for (int i = 0; i < NDIG; i++) begin
            p[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {co, p};
    endfunction

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- directed instance ----------------
    logic         d_rst_n = 1'b0;
    logic         d_iv = 1'b0, d_ordy = 1'b0, d_cin = 1'b0;
    logic [W-1:0] d_s = '0, d_h = '0;
    logic         d_ir, d_ov, d_co;
    logic [W-1:0] d_p;

    dec_final_adder_seq #(.NDIG(NDIG), .CHUNK(2)) u_dut (
        .clk(clk), .rst_n(d_rst_n),
        .in_valid(d_iv), .in_ready(d_ir),
        .s_4221(d_s), .h_4221(d_h), .cin(d_cin),
        .out_valid(d_ov), .out_ready(d_ordy),
        .p_bcd(d_p), .cout(d_co)
    );

    // Called on the negedge right after the accept edge; counts cycles to out_valid.
    task automatic wait_result(output int lat, output logic [W-1:0] p, output logic co);
        lat = 0;
        while (!d_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        p  = d_p;
        co = d_co;
    endtask

    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] h, input logic c,
                          output int lat, output logic [W-1:0] p, output logic co);
        @(negedge clk);
        d_s = s; d_h = h; d_cin = c; d_iv = 1'b1; d_ordy = 1'b0;
        @(negedge clk);
        d_iv = 1'b0;
        d_s = '1; d_h = '1; d_cin = 1'b1;   // post-accept changes must not matter
        wait_result(lat, p, co);
    endtask

    task automatic release_out();
        @(negedge clk);
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        chk("release out_valid", d_ov, 0);
    endtask

    // ---------------- random sweep instances ----------------
    logic rst_n = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int CH  = 1 << g;
        localparam int NCH = NDIG / CH;
        logic         iv = 1'b0, ordy = 1'b0, c = 1'b0;
        logic [W-1:0] s = '0, h = '0;
        logic         ir, ov, co;
        logic [W-1:0] p;
        bit           done = 1'b0;

        dec_final_adder_seq #(.NDIG(NDIG), .CHUNK(CH)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir),
            .s_4221(s), .h_4221(h), .cin(c),
            .out_valid(ov), .out_ready(ordy),
            .p_bcd(p), .cout(co)
        );

        // Single compare process: one result in flight at most, expected in order.
        initial begin
            exp_t  q[$];
            exp_t  e;
            int    cyc;
            int    nres;
            bit    seen;
            string tag;
            cyc = 0; nres = 0; seen = 1'b0;
            tag = $sformatf("sweep chunk%0d", CH);
            wait (rst_n);
            while (nres < 1000 && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                if (ov) begin
                    if (q.size() == 0) chk({tag, " spurious out_valid"}, ov, 0);
                    else begin
                        if (!seen) begin
                            chk({tag, " latency"}, W'(cyc - q[0].cyc - 1), W'(NCH));
                            seen = 1'b1;
                        end
                        chk({tag, " result"}, {co, p}, {q[0].co, q[0].p});
                    end
                end
                iv   = ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 6);
                s    = $urandom;
                h    = $urandom;
                c    = 1'($urandom_range(0, 1));
                #1;
                chk({tag, " in_ready"}, ir, (q.size() == 0) ? 1 : (ov ? ordy : 0));
                if (ov && ordy && q.size() != 0) begin
                    void'(q.pop_front());
                    nres++;
                    seen = 1'b0;
                end
                if (iv && ir) begin
                    {e.co, e.p} = model(s, h, c);
                    e.cyc = cyc;
                    q.push_back(e);
                end
            end
            if (nres < 1000) chk({tag, " results before timeout"}, W'(nres), W'(1000));
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        logic [W-1:0] p, p0, snew, hnew;
        logic         co, co0;

        repeat (2) @(negedge clk);
        chk("reset out_valid", d_ov, 0);
        chk("reset in_ready", d_ir, 1);
        chk("reset p_bcd", d_p, 0);
        chk("reset cout", d_co, 0);
        d_rst_n = 1'b1;
        rst_n   = 1'b1;

        // Model pinned against hand-worked values.
        chk("model 6+6", model(32'h0000000C, 32'h0000000A, 1'b0), 33'h0_00000012);
        chk("model all9+1", model(32'hFFFFFFFF, 32'h00000001, 1'b0), 33'h1_00000000);
        chk("model 1234", model(32'h00001234, 32'h0, 1'b0), 33'h0_00001232);

        run_op(32'h0, 32'h0, 1'b0, lat, p, co);
        chk("zero latency", W'(lat), W'(4));
        chk("zero result", {co, p}, 33'h0_00000000);
        release_out();

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, p, co);
        chk("ripple result", {co, p}, 33'h1_00000000);
        release_out();

        run_op(32'h0000000C, 32'h0000000A, 1'b0, lat, p, co);
        chk("6+6 result", {co, p}, 33'h0_00000012);
        release_out();
        run_op(32'h0000000A, 32'h0000000C, 1'b0, lat, p, co);
        chk("6+6 swapped", {co, p}, 33'h0_00000012);
        release_out();

        // Back-pressure, then accept a new pair on the same edge the result leaves.
        snew = $urandom; hnew = $urandom;
        run_op(snew, hnew, 1'b1, lat, p0, co0);
        chk("bp first result", {co0, p0}, model(snew, hnew, 1'b1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", d_ov, 1);
            chk("bp hold", {d_co, d_p}, {co0, p0});
            chk("bp in_ready", d_ir, 0);
        end
        @(negedge clk);
        snew = $urandom; hnew = $urandom;
        d_s = snew; d_h = hnew; d_cin = 1'b0; d_iv = 1'b1; d_ordy = 1'b1;
        #1;
        chk("bp passthrough in_ready", d_ir, 1);
        @(negedge clk);
        d_iv = 1'b0; d_ordy = 1'b0;
        chk("bp next busy out_valid", d_ov, 0);
        chk("bp next busy in_ready", d_ir, 0);
        wait_result(lat, p, co);
        chk("bp next latency", W'(lat), W'(4));
        chk("bp next result", {co, p}, model(snew, hnew, 1'b0));
        release_out();

        // Reset during BUSY kills the operation.
        @(negedge clk);
        d_s = 32'h99999999; d_h = 32'h12345678; d_iv = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        @(negedge clk);
        d_rst_n = 1'b0;
        #1;
        chk("midreset out_valid", d_ov, 0);
        chk("midreset in_ready", d_ir, 1);
        chk("midreset p_bcd", d_p, 0);
        @(negedge clk);
        d_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midreset no result", d_ov, 0);
        run_op(32'h00001234, 32'h0, 1'b0, lat, p, co);
        chk("after reset latency", W'(lat), W'(4));
        chk("after reset result", {co, p}, 33'h0_00001232);
        release_out();

        wait (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
